m2vside_queue: RTL and testbench

M2VSIDE_QUEUE -- requirements
Module: m2vside_queue

---
 rtl/m2v_pkg.sv | 30 +++
 rtl/m2vside_ram.sv | 26 ++
 rtl/m2vside_queue.sv | 163 ++++++++++++++++
 tb/tb_m2vside_queue.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m2v_pkg.sv
// Shared side-information record layout for the MPEG-2 video side queue.
// Fields are packed LSB-first: enable, coded, block[2:0], intra, mb_y, mb_x, mv_v, mv_h.
package m2v_pkg;

   localparam int FLAG_W     = 6;
   localparam int BLOCK_W    = 3;
   localparam int OFF_ENABLE = 0;
   localparam int OFF_CODED  = 1;
   localparam int OFF_BLOCK  = 2;
   localparam int OFF_INTRA  = 5;
   localparam int OFF_MB_Y   = FLAG_W;

   function automatic int side_width(input int mvh_w, input int mvv_w,
                                     input int mbx_w, input int mby_w);
      return mvh_w + mvv_w + mbx_w + mby_w + FLAG_W;
   endfunction

   function automatic int off_mb_x(input int mby_w);
      return OFF_MB_Y + mby_w;
   endfunction

   function automatic int off_mv_v(input int mbx_w, input int mby_w);
      return off_mb_x(mby_w) + mbx_w;
   endfunction

   function automatic int off_mv_h(input int mvv_w, input int mbx_w, input int mby_w);
      return off_mv_v(mbx_w, mby_w) + mvv_w;
   endfunction

endpackage

// File: rtl/m2vside_ram.sv
// Record storage: one synchronous write port, one asynchronous read port, no reset.
module m2vside_ram #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2,
   parameter int WIDTH  = 36
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/m2vside_queue.sv
// Side-information queue between the MPEG-2 parser and block decoder.
// block_start pops the head into registered out_* fields; empty pops zero them and flag underflow.
module m2vside_queue
   import m2v_pkg::*;
#(
   parameter int MVH_WIDTH = 10,
   parameter int MVV_WIDTH = 10,
   parameter int MBX_WIDTH = 6,
   parameter int MBY_WIDTH = 5,
   parameter int DEPTH     = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         flush,
   input  logic [MVH_WIDTH-1:0]         in_mv_h,
   input  logic [MVV_WIDTH-1:0]         in_mv_v,
   input  logic [MBX_WIDTH-1:0]         in_mb_x,
   input  logic [MBY_WIDTH-1:0]         in_mb_y,
   input  logic                         in_mb_intra,
   input  logic                         in_coded,
   input  logic                         in_enable,
   input  logic [2:0]                   in_block,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         block_start,
   output logic [MVH_WIDTH-1:0]         out_mv_h,
   output logic [MVV_WIDTH-1:0]         out_mv_v,
   output logic [MBX_WIDTH-1:0]         out_mb_x,
   output logic [MBY_WIDTH-1:0]         out_mb_y,
   output logic                         out_mb_intra,
   output logic [2:0]                   out_block,
   output logic                         out_coded,
   output logic                         out_enable,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full,
   output logic                         err_ovf,
   output logic                         err_udf
);

   localparam int SIDE_W  = side_width(MVH_WIDTH, MVV_WIDTH, MBX_WIDTH, MBY_WIDTH);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int OFF_MBX = off_mb_x(MBY_WIDTH);
   localparam int OFF_MVV = off_mv_v(MBX_WIDTH, MBY_WIDTH);
   localparam int OFF_MVH = off_mv_h(MVV_WIDTH, MBX_WIDTH, MBY_WIDTH);

   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [SIDE_W-1:0] out_rec_q, out_rec_d;
   logic              err_ovf_q, err_ovf_d;
   logic              err_udf_q, err_udf_d;

   logic              empty_s, full_s, push_s, pop_s, we_s;
   logic [SIDE_W-1:0] wr_data_s, rd_data_s;

   assign wr_data_s = {in_mv_h, in_mv_v, in_mb_x, in_mb_y,
                       in_mb_intra, in_block, in_coded, in_enable};

   assign empty_s = (count_q == {CNT_W{1'b0}});
   assign full_s  = (count_q == CNT_FULL);
   assign push_s  = in_valid & ~full_s;
   assign pop_s   = block_start & ~empty_s;
   assign we_s    = push_s & ~flush;

   m2vside_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W),
      .WIDTH  (SIDE_W)
   ) u_ram (
      .clk   (clk),
      .we    (we_s),
      .waddr (wr_ptr_q),
      .wdata (wr_data_s),
      .raddr (rd_ptr_q),
      .rdata (rd_data_s)
   );

   // Next-state: pointers, occupancy, output record and sticky errors.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      out_rec_d = out_rec_q;
      err_ovf_d = err_ovf_q;
      err_udf_d = err_udf_q;
      if (flush) begin
         wr_ptr_d  = {PTR_W{1'b0}};
         rd_ptr_d  = {PTR_W{1'b0}};
         count_d   = {CNT_W{1'b0}};
         out_rec_d = {SIDE_W{1'b0}};
         err_ovf_d = 1'b0;
         err_udf_d = 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         // No bypass: an empty pop zeroes the outputs even if a push lands on the same edge.
         if (pop_s) begin
            out_rec_d = rd_data_s;
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
         end else if (block_start) begin
            out_rec_d = {SIDE_W{1'b0}};
            err_udf_d = 1'b1;
         end else begin
            out_rec_d = out_rec_q;
         end
         if (in_valid && full_s) begin
            err_ovf_d = 1'b1;
         end else begin
            err_ovf_d = err_ovf_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q  <= {PTR_W{1'b0}};
         rd_ptr_q  <= {PTR_W{1'b0}};
         count_q   <= {CNT_W{1'b0}};
         out_rec_q <= {SIDE_W{1'b0}};
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         out_rec_q <= out_rec_d;
         err_ovf_q <= err_ovf_d;
         err_udf_q <= err_udf_d;
      end
   end

   assign out_enable   = out_rec_q[OFF_ENABLE];
   assign out_coded    = out_rec_q[OFF_CODED];
   assign out_block    = out_rec_q[OFF_BLOCK +: BLOCK_W];
   assign out_mb_intra = out_rec_q[OFF_INTRA];
   assign out_mb_y     = out_rec_q[OFF_MB_Y +: MBY_WIDTH];
   assign out_mb_x     = out_rec_q[OFF_MBX +: MBX_WIDTH];
   assign out_mv_v     = out_rec_q[OFF_MVV +: MVV_WIDTH];
   assign out_mv_h     = out_rec_q[OFF_MVH +: MVH_WIDTH];

   assign count    = count_q;
   assign empty    = empty_s;
   assign full     = full_s;
   assign in_ready = ~full_s;
   assign err_ovf  = err_ovf_q;
   assign err_udf  = err_udf_q;

endmodule

// File: tb/tb_m2vside_queue.sv
// Self-checking bench for m2vside_queue: directed table, corner sequences and random traffic
// checked against a queue-based reference model.
module tb_m2vside_queue;

   localparam int MVH = 10, MVV = 10, MBX = 6, MBY = 5, DEPTH = 4, CNT_W = 3;

   typedef struct packed {
      logic [MVH-1:0] mv_h;
      logic [MVV-1:0] mv_v;
      logic [MBX-1:0] mb_x;
      logic [MBY-1:0] mb_y;
      logic           intra;
      logic [2:0]     blk;
      logic           coded;
      logic           enable;
   } rec_t;

   typedef struct {
      logic       v;
      logic       bs;
      logic       fl;
      logic [5:0] mbx;
      int         cnt;
      logic [5:0] omx;
      logic       full;
      logic       ovf;
      logic       udf;
   } vec_t;

   logic             clk, reset_n, flush;
   logic [MVH-1:0]   in_mv_h;
   logic [MVV-1:0]   in_mv_v;
   logic [MBX-1:0]   in_mb_x;
   logic [MBY-1:0]   in_mb_y;
   logic             in_mb_intra, in_coded, in_enable, in_valid, in_ready, block_start;
   logic [2:0]       in_block;
   logic [MVH-1:0]   out_mv_h;
   logic [MVV-1:0]   out_mv_v;
   logic [MBX-1:0]   out_mb_x;
   logic [MBY-1:0]   out_mb_y;
   logic             out_mb_intra, out_coded, out_enable;
   logic [2:0]       out_block;
   logic [CNT_W-1:0] count;
   logic             empty, full, err_ovf, err_udf;

   m2vside_queue #(
      .MVH_WIDTH(MVH), .MVV_WIDTH(MVV), .MBX_WIDTH(MBX), .MBY_WIDTH(MBY), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_mv_h(in_mv_h), .in_mv_v(in_mv_v), .in_mb_x(in_mb_x), .in_mb_y(in_mb_y),
      .in_mb_intra(in_mb_intra), .in_coded(in_coded), .in_enable(in_enable),
      .in_block(in_block), .in_valid(in_valid), .in_ready(in_ready),
      .block_start(block_start),
      .out_mv_h(out_mv_h), .out_mv_v(out_mv_v), .out_mb_x(out_mb_x), .out_mb_y(out_mb_y),
      .out_mb_intra(out_mb_intra), .out_block(out_block), .out_coded(out_coded),
      .out_enable(out_enable), .count(count), .empty(empty), .full(full),
      .err_ovf(err_ovf), .err_udf(err_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   rec_t m_q[$];
   rec_t m_out;
   logic m_ovf, m_udf;
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t tbl[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic rec_t dut_out();
      rec_t r;
      r.mv_h = out_mv_h; r.mv_v = out_mv_v; r.mb_x = out_mb_x; r.mb_y = out_mb_y;
      r.intra = out_mb_intra; r.blk = out_block; r.coded = out_coded; r.enable = out_enable;
      return r;
   endfunction

   function automatic rec_t cur_in();
      rec_t r;
      r.mv_h = in_mv_h; r.mv_v = in_mv_v; r.mb_x = in_mb_x; r.mb_y = in_mb_y;
      r.intra = in_mb_intra; r.blk = in_block; r.coded = in_coded; r.enable = in_enable;
      return r;
   endfunction

   function automatic rec_t rand_rec();
      logic [63:0] x;
      x = {$urandom(), $urandom()};
      return x[$bits(rec_t)-1:0];
   endfunction

   function automatic rec_t mk_rec(input logic [MBX-1:0] mbx, input logic [MVH-1:0] mvh,
                                   input logic [MVV-1:0] mvv);
      rec_t r;
      r = '0;
      r.mb_x = mbx; r.mv_h = mvh; r.mv_v = mvv;
      r.mb_y = 5'd17; r.blk = 3'd5; r.intra = 1'b1; r.coded = 1'b0; r.enable = 1'b1;
      return r;
   endfunction

   task automatic apply(input logic v, input logic bs, input logic fl, input rec_t r);
      in_valid = v; block_start = bs; flush = fl;
      in_mv_h = r.mv_h; in_mv_v = r.mv_v; in_mb_x = r.mb_x; in_mb_y = r.mb_y;
      in_mb_intra = r.intra; in_block = r.blk; in_coded = r.coded; in_enable = r.enable;
   endtask

   task automatic model_reset();
      m_q.delete();
      m_out = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   // Reference behaviour of one clock edge, from the current inputs.
   task automatic model_step();
      bit was_full;
      was_full = (m_q.size() == DEPTH);
      if (flush) begin
         model_reset();
      end else begin
         if (in_valid && was_full) m_ovf = 1'b1;
         if (block_start) begin
            if (m_q.size() == 0) begin
               m_out = '0;
               m_udf = 1'b1;
            end else begin
               m_out = m_q.pop_front();
            end
         end
         if (in_valid && !was_full) m_q.push_back(cur_in());
      end
   endtask

   task automatic compare_model();
      check("out_rec", 64'(dut_out()), 64'(m_out));
      check("count", 64'(count), 64'(m_q.size()));
      check("empty", 64'(empty), 64'(m_q.size() == 0));
      check("full", 64'(full), 64'(m_q.size() == DEPTH));
      check("in_ready", 64'(in_ready), 64'(m_q.size() != DEPTH));
      check("err_ovf", 64'(err_ovf), 64'(m_ovf));
      check("err_udf", 64'(err_udf), 64'(m_udf));
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_out"}, 64'(dut_out()), 64'd0);
      check({tag, "_count"}, 64'(count), 64'd0);
      check({tag, "_empty"}, 64'(empty), 64'd1);
      check({tag, "_full"}, 64'(full), 64'd0);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_ovf"}, 64'(err_ovf), 64'd0);
      check({tag, "_udf"}, 64'(err_udf), 64'd0);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'd1, 1, 6'd0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 6'd2, 2, 6'd0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 6'd3, 3, 6'd0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 6'd0, 2, 6'd1, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 6'd4, 3, 6'd1, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 6'd5, 4, 6'd1, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 6'd6, 4, 6'd1, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 6'd9, 3, 6'd2, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 6'd0, 2, 6'd3, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 6'd0, 1, 6'd4, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 6'd0, 0, 6'd5, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 6'd0, 0, 6'd0, 1'b0, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 6'd0, 0, 6'd0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 6'd0, 0, 6'd0, 1'b0, 1'b0, 1'b1};
      tbl[14] = '{1'b1, 1'b1, 1'b0, 6'd7, 1, 6'd0, 1'b0, 1'b0, 1'b1};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 6'd0, 0, 6'd7, 1'b0, 1'b0, 1'b1};

      reset_n = 1'b0;
      apply(1'b0, 1'b0, 1'b0, '0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      #2 reset_n = 1'b1;

      // Directed table: fill, overflow, pop-at-full, drain, underflow, flush, no-bypass.
      for (int i = 0; i < 16; i++) begin
         apply(tbl[i].v, tbl[i].bs, tbl[i].fl, mk_rec(tbl[i].mbx, MVH'(i * 37), MVV'(i * 11)));
         step();
         check($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
         check($sformatf("tbl%0d_out_mb_x", i), 64'(out_mb_x), 64'(tbl[i].omx));
         check($sformatf("tbl%0d_full", i), 64'(full), 64'(tbl[i].full));
         check($sformatf("tbl%0d_ovf", i), 64'(err_ovf), 64'(tbl[i].ovf));
         check($sformatf("tbl%0d_udf", i), 64'(err_udf), 64'(tbl[i].udf));
      end

      // Simultaneous push and pop at count=2 keeps count and order.
      apply(1'b1, 1'b0, 1'b0, mk_rec(6'd10, 10'h001, 10'h002)); step();
      apply(1'b1, 1'b0, 1'b0, mk_rec(6'd11, 10'h003, 10'h004)); step();
      apply(1'b1, 1'b1, 1'b0, mk_rec(6'd12, 10'h005, 10'h006)); step();
      check("s4_count", 64'(count), 64'd2);
      check("s4_first", 64'(out_mb_x), 64'd10);
      apply(1'b0, 1'b1, 1'b0, '0); step();
      check("s4_second", 64'(out_mb_x), 64'd11);
      apply(1'b0, 1'b1, 1'b0, '0); step();
      check("s4_third", 64'(out_mb_x), 64'd12);
      check("s4_empty", 64'(empty), 64'd1);

      // Pointer wrap with extreme motion vectors.
      apply(1'b1, 1'b0, 1'b0, mk_rec(6'd40, 10'h3FF, 10'h200)); step();
      for (int i = 0; i < 10; i++) begin
         apply(1'b1, 1'b1, 1'b0, mk_rec(6'(41 + i), 10'h3FF, 10'h200));
         step();
         check($sformatf("wrap%0d_mv_h", i), 64'(out_mv_h), 64'h3FF);
         check($sformatf("wrap%0d_mv_v", i), 64'(out_mv_v), 64'h200);
         check($sformatf("wrap%0d_mb_x", i), 64'(out_mb_x), 64'(40 + i));
      end

      // Flush at count=3, then asynchronous reset in the middle of a push.
      apply(1'b1, 1'b0, 1'b0, mk_rec(6'd20, 10'h0AA, 10'h155)); step();
      apply(1'b1, 1'b0, 1'b0, mk_rec(6'd21, 10'h0AB, 10'h156)); step();
      check("s6_count3", 64'(count), 64'd3);
      apply(1'b0, 1'b0, 1'b1, '0); step();
      check("s6_flush_count", 64'(count), 64'd0);
      check("s6_flush_out", 64'(dut_out()), 64'd0);
      apply(1'b1, 1'b0, 1'b0, mk_rec(6'd22, 10'h111, 10'h222)); step();
      apply(1'b1, 1'b0, 1'b0, mk_rec(6'd23, 10'h333, 10'h044)); step();
      check("s6_pre_reset_count", 64'(count), 64'd2);
      #3 reset_n = 1'b0;
      #1;
      model_reset();
      check_reset_vals("async_reset");
      apply(1'b0, 1'b0, 1'b0, '0);
      @(posedge clk);
      #1;
      check_reset_vals("reset_held");
      #2 reset_n = 1'b1;
      apply(1'b0, 1'b1, 1'b0, '0); step();
      check("post_reset_udf", 64'(err_udf), 64'd1);

      // Random traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         apply(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
               1'($urandom_range(0, 99) < 3), rand_rec());
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
